// File: rtl/control_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : control_unit                                                 |
// | Description : Hardwired FSM sequencer producing the 23-bit datapath        |
// |               control word. Fetches from IRAM, decodes ir_in[15:8], steps  |
// |               through per-instruction microsteps and returns to FETCH.     |
// |               Reports busy/halted/illegal and a retired-instruction count. |
// | Ports       : clock   - system clock, rising edge                          |
// |               reset   - synchronous, active-high                           |
// |               start   - launches execution, sampled only in IDLE           |
// |               ir_in   - datapath IR; opcode = ir_in[15:8]                  |
// |               ac_zero - AC == 0 flag, sampled in DECODE for JMPZ           |
// |               control - datapath control word                              |
// |               busy    - high outside IDLE/HALT                             |
// |               halted  - high in HALT                                       |
// |               illegal - sticky undefined-opcode flag                       |
// |               retired - completed-instruction count, wraps                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module control_unit #(
  parameter int CTRL_W = 23,
  parameter int OPC_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       ir_in,
  input  logic              ac_zero,
  output logic [CTRL_W-1:0] control,
  output logic              busy,
  output logic              halted,
  output logic              illegal,
  output logic [CNT_W-1:0]  retired
);

  // Control word field positions
  localparam int B_DRAM_WE = 0;
  localparam int B_PC_INC  = 1;
  localparam int BUS_LO    = 2;
  localparam int BUS_HI    = 4;
  localparam int ALU_LO    = 8;
  localparam int ALU_HI    = 9;
  localparam int B_R_WE    = 14;
  localparam int B_AR_WE   = 15;
  localparam int B_DR_WE   = 16;
  localparam int B_AC_WE   = 17;
  localparam int B_PC_WE   = 18;
  localparam int B_IR_WE   = 19;
  localparam int ADDR_LO   = 20;
  localparam int ADDR_HI   = 21;
  localparam int B_AC_ALU  = 22;

  localparam logic [2:0] BUS_IR   = 3'd2;
  localparam logic [2:0] BUS_DR   = 3'd3;
  localparam logic [2:0] BUS_R    = 3'd4;
  localparam logic [2:0] BUS_AC   = 3'd5;
  localparam logic [2:0] BUS_DRAM = 3'd6;
  localparam logic [2:0] BUS_IRAM = 3'd7;

  localparam logic [1:0] ALU_ADD = 2'b01;
  localparam logic [1:0] ALU_SUB = 2'b10;
  localparam logic [1:0] ALU_INC = 2'b11;
  localparam logic [1:0] ADDR_PC = 2'b01;

  localparam logic [OPC_W-1:0] OP_NOP   = 'h00;
  localparam logic [OPC_W-1:0] OP_LDAC  = 'h01;
  localparam logic [OPC_W-1:0] OP_STAC  = 'h02;
  localparam logic [OPC_W-1:0] OP_MVACR = 'h03;
  localparam logic [OPC_W-1:0] OP_MVRAC = 'h04;
  localparam logic [OPC_W-1:0] OP_ADD   = 'h05;
  localparam logic [OPC_W-1:0] OP_SUB   = 'h06;
  localparam logic [OPC_W-1:0] OP_JUMP  = 'h07;
  localparam logic [OPC_W-1:0] OP_JMPZ  = 'h08;
  localparam logic [OPC_W-1:0] OP_INAC  = 'h09;
  localparam logic [OPC_W-1:0] OP_HALT  = 'hFF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EX1    = 3'd3,
    S_EX2    = 3'd4,
    S_EX3    = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [OPC_W-1:0]  opcode_q, opcode_d;
  logic              illegal_q, illegal_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic [CTRL_W-1:0] control_q, control_d;
  logic              busy_q, busy_d;
  logic              halted_q, halted_d;
  logic              retire_now;

  // The operand byte is routed to the bus by the datapath itself.
  logic unused_ir_lo;
  assign unused_ir_lo = ^ir_in[7:0];

  // Control word for a given state/opcode pair; every unlisted field is 0.
  function automatic logic [CTRL_W-1:0] ctrl_word(input state_t st, input logic [OPC_W-1:0] opc);
    logic [CTRL_W-1:0] c;
    c = '0;
    case (st)
      S_FETCH: begin
        c[ADDR_HI:ADDR_LO] = ADDR_PC;
        c[BUS_HI:BUS_LO]   = BUS_IRAM;
        c[B_IR_WE]         = 1'b1;
        c[B_PC_INC]        = 1'b1;
      end
      S_EX1: begin
        case (opc)
          OP_LDAC, OP_STAC: begin
            c[BUS_HI:BUS_LO] = BUS_IR;
            c[B_AR_WE]       = 1'b1;
          end
          OP_MVACR: begin
            c[BUS_HI:BUS_LO] = BUS_AC;
            c[B_R_WE]        = 1'b1;
          end
          OP_MVRAC: begin
            c[BUS_HI:BUS_LO] = BUS_R;
            c[B_AC_WE]       = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            c[BUS_HI:BUS_LO] = BUS_R;
            c[ALU_HI:ALU_LO] = (opc == OP_ADD) ? ALU_ADD : ALU_SUB;
            c[B_AC_WE]       = 1'b1;
            c[B_AC_ALU]      = 1'b1;
          end
          OP_INAC: begin
            c[ALU_HI:ALU_LO] = ALU_INC;
            c[B_AC_WE]       = 1'b1;
            c[B_AC_ALU]      = 1'b1;
          end
          // Only a taken JMPZ ever reaches EX1.
          OP_JUMP, OP_JMPZ: begin
            c[BUS_HI:BUS_LO] = BUS_IR;
            c[B_PC_WE]       = 1'b1;
          end
          default: ;
        endcase
      end
      S_EX2: begin
        if (opc == OP_LDAC) begin
          c[BUS_HI:BUS_LO] = BUS_DRAM;
          c[B_DR_WE]       = 1'b1;
        end else if (opc == OP_STAC) begin
          c[BUS_HI:BUS_LO] = BUS_AC;
          c[B_DRAM_WE]     = 1'b1;
        end
      end
      S_EX3: begin
        if (opc == OP_LDAC) begin
          c[BUS_HI:BUS_LO] = BUS_DR;
          c[B_AC_WE]       = 1'b1;
        end
      end
      default: ;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    illegal_d  = illegal_q;
    retire_now = 1'b0;
    case (state_q)
      S_IDLE:  if (start) state_d = S_FETCH;
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        opcode_d = ir_in[15 -: OPC_W];
        case (opcode_d)
          OP_NOP: begin
            state_d    = S_FETCH;
            retire_now = 1'b1;
          end
          OP_HALT: begin
            state_d    = S_HALT;
            retire_now = 1'b1;
          end
          OP_JMPZ: begin
            // Untaken branch completes in DECODE.
            state_d    = ac_zero ? S_EX1 : S_FETCH;
            retire_now = ~ac_zero;
          end
          OP_LDAC, OP_STAC, OP_MVACR, OP_MVRAC,
          OP_ADD, OP_SUB, OP_INAC, OP_JUMP: state_d = S_EX1;
          default: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_EX1: begin
        if (opcode_q == OP_LDAC || opcode_q == OP_STAC) begin
          state_d = S_EX2;
        end else begin
          state_d    = S_FETCH;
          retire_now = 1'b1;
        end
      end
      S_EX2: begin
        if (opcode_q == OP_LDAC) begin
          state_d = S_EX3;
        end else begin
          state_d    = S_FETCH;
          retire_now = 1'b1;
        end
      end
      S_EX3: begin
        state_d    = S_FETCH;
        retire_now = 1'b1;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    retired_d = retired_q + {{(CNT_W-1){1'b0}}, retire_now};
    // Outputs are registered: decode them from the state being entered.
    control_d = ctrl_word(state_d, opcode_d);
    busy_d    = (state_d != S_IDLE) && (state_d != S_HALT);
    halted_d  = (state_d == S_HALT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      opcode_q  <= '0;
      illegal_q <= 1'b0;
      retired_q <= '0;
      control_q <= '0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
      control_q <= control_d;
      busy_q    <= busy_d;
      halted_q  <= halted_d;
    end
  end

  assign control = control_q;
  assign busy    = busy_q;
  assign halted  = halted_q;
  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule
`default_nettype wire
